// File: rtl/parity_receiver_pkg.sv
// Shared types and constants for the serial parity receiver.
`timescale 1ns/1ps
package parity_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } state_t;

  localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

endpackage

// File: rtl/parity_receiver.sv
// Serial MSB-first frame receiver: WIDTH data bits followed by one parity bit,
// with a saturating parity-error counter.
`timescale 1ns/1ps
module parity_receiver
  import parity_receiver_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             parity_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_error,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic [7:0]       errs_q, errs_d;
  logic             mismatch;

  assign mismatch = parity_in != (par_q ^ ODD_PARITY);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    errs_d  = errs_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      StShift: begin
        shift_d = {shift_q[WIDTH-2:0], serial_in};
        par_d   = par_q ^ serial_in;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Publish the word only here so data_out never shows a partial frame.
        dout_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = mismatch;
        if (mismatch && (errs_q != ERR_COUNT_MAX)) begin
          errs_d = errs_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      errs_q  <= errs_d;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign busy         = (state_q != StIdle);
  assign err_count    = errs_q;

endmodule

// File: tb/tb_parity_receiver.sv
// Scoreboard bench: even- and odd-parity receivers driven in lockstep.
`timescale 1ns/1ps
module tb_parity_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       serial_in = 1'b0;
  logic       parity_in = 1'b0;
  logic [7:0] dout_e, dout_o, errs_e, errs_o;
  logic       dv_e, dv_o, perr_e, perr_o, busy_e, busy_o;

  parity_receiver #(.WIDTH(8), .ODD_PARITY(1'b0)) dut_even (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in),
    .parity_in(parity_in), .data_out(dout_e), .data_valid(dv_e),
    .parity_error(perr_e), .busy(busy_e), .err_count(errs_e)
  );

  parity_receiver #(.WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in),
    .parity_in(parity_in), .data_out(dout_o), .data_valid(dv_o),
    .parity_error(perr_o), .busy(busy_o), .err_count(errs_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q_e[$];
  exp_t       q_o[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cnt_e = 0;
  int         cnt_o = 0;
  logic [7:0] exp_dout_e = 8'h00;
  logic [7:0] exp_dout_o = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a receiver presents a word.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (dv_e === 1'b1) begin
        if (q_e.size() == 0) begin
          chk("even_unexpected_valid", 32'(dv_e), 32'd0);
        end else begin
          e = q_e.pop_front();
          chk("even_latency", 32'(cyc), 32'(e.cyc));
          chk("even_data", 32'(dout_e), 32'(e.data));
          chk("even_perr", 32'(perr_e), 32'(e.err));
          chk("even_errcnt", 32'(errs_e), 32'(e.cnt));
          exp_dout_e = e.data;
        end
      end else begin
        chk("even_perr_idle", 32'(perr_e), 32'd0);
        chk("even_data_hold", 32'(dout_e), 32'(exp_dout_e));
      end
      if (dv_o === 1'b1) begin
        if (q_o.size() == 0) begin
          chk("odd_unexpected_valid", 32'(dv_o), 32'd0);
        end else begin
          e = q_o.pop_front();
          chk("odd_latency", 32'(cyc), 32'(e.cyc));
          chk("odd_data", 32'(dout_o), 32'(e.data));
          chk("odd_perr", 32'(perr_o), 32'(e.err));
          chk("odd_errcnt", 32'(errs_o), 32'(e.cnt));
          exp_dout_o = e.data;
        end
      end else begin
        chk("odd_perr_idle", 32'(perr_o), 32'd0);
        chk("odd_data_hold", 32'(dout_o), 32'(exp_dout_o));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout_e"}, 32'(dout_e), 32'd0);
    chk({tag, "_dv_e"}, 32'(dv_e), 32'd0);
    chk({tag, "_perr_e"}, 32'(perr_e), 32'd0);
    chk({tag, "_busy_e"}, 32'(busy_e), 32'd0);
    chk({tag, "_errs_e"}, 32'(errs_e), 32'd0);
    chk({tag, "_dout_o"}, 32'(dout_o), 32'd0);
    chk({tag, "_busy_o"}, 32'(busy_o), 32'd0);
    chk({tag, "_errs_o"}, 32'(errs_o), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_all_zero(tag);
    q_e.delete();
    q_o.delete();
    cnt_e = 0;
    cnt_o = 0;
    exp_dout_e = 8'h00;
    exp_dout_o = 8'h00;
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  // ee/eo are the hand-computed parity_error values for the even/odd receivers.
  task automatic send_frame(input logic [7:0] bits, input logic pin, input logic ee,
                            input logic eo, input int glitch);
    exp_t e;
    if (ee && cnt_e < 255) cnt_e++;
    if (eo && cnt_o < 255) cnt_o++;
    e.data = bits; e.err = ee; e.cnt = 8'(cnt_e); e.cyc = cyc + 10;
    q_e.push_back(e);
    e.err = eo; e.cnt = 8'(cnt_o);
    q_o.push_back(e);
    start = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      serial_in = bits[7-i];
      start = (i == glitch);
      if (i == 4) begin
        chk("busy_e_mid", 32'(busy_e), 32'd1);
        chk("busy_o_mid", 32'(busy_o), 32'd1);
      end
      @(negedge clock);
    end
    start = 1'b0;
    parity_in = pin;
    @(negedge clock);
    parity_in = 1'b0;
  endtask

  task automatic abort_frame(input logic [7:0] bits);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = bits[7-i];
      @(negedge clock);
    end
    do_reset("abort");
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    do_reset("por");
    send_frame(8'hEA, 1'b1, 1'b0, 1'b1, -1);  // 5 ones
    idle(2);
    send_frame(8'hEA, 1'b0, 1'b1, 1'b0, -1);
    idle(1);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, -1);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, -1);
    idle(2);
    abort_frame(8'hEA);
    idle(3);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1);  // 4 ones
    idle(1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 2);   // extra start during bit 3
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, -1);  // back-to-back
    idle(2);
    for (int k = 0; k < 260; k++) begin
      send_frame(8'hEA, 1'b0, 1'b1, 1'b0, -1);
    end
    idle(3);
    chk("even_errcnt_saturated", 32'(errs_e), 32'd255);
    chk("even_queue_drained", 32'(q_e.size()), 32'd0);
    chk("odd_queue_drained", 32'(q_o.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected finish before 100000 ns");
    $fatal(1);
  end

endmodule
